mont_domain_xfer_n: RTL and testbench
=====================================

Name: mont_domain_xfer_n

Overview:
Parametrised converter between regular and Montgomery representation for the ECC datapath. It moves NCH field elements at once: into the domain (x·2^RBITS mod p) or out of it (x·2^-RBITS mod p). It iterates one bit per cycle, using modular doubling or modular halving, with a valid/ready handshake on both sides. It sits between the point-load interface and the point-arithmetic core, and again on the result path.

Parameters:
WIDTH, 32, field element and prime width in bits
NCH, 3, number of channels converted in parallel (e.g. Px, Py, A)
RBITS, 32, Montgomery exponent (R = 2^RBITS); iteration count, 1..2^16-1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  request carries a valid job
in_ready  output  1  block can accept a job (high only in IDLE)
to_mont  input  1  1 = regular→Montgomery, 0 = Montgomery→regular; sampled at accept
prime  input  WIDTH  modulus p; sampled at accept
data_i  input  NCH*WIDTH  channel k in bits [k*WIDTH +: WIDTH]
out_valid  output  1  result available
out_ready  input  1  consumer takes result
data_o  output  NCH*WIDTH  converted values, same packing as data_i
err_even  output  1  qualified by out_valid; job had an even prime and no conversion was done
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: all state on posedge clk. reset is asynchronous, active-low.
- Reset values: state=IDLE, counter=0, data regs=0, prime reg=0, mode reg=0, out_valid=0, err_even=0, busy=0, in_ready=1.
- States: IDLE, ITER, OUT.
- IDLE:
  - in_ready=1.
  - Accept occurs on a cycle with in_valid&in_ready.
  - At accept, latch prime and to_mont.
  - Each channel loads with one conditional subtract: data_i_k >= prime ? data_i_k - prime : data_i_k. Inputs >= 2p are reduced only once; callers guarantee inputs < 2p.
  - If prime[0]==0 (this includes p=0): go to OUT with err_even=1 and the reduced values unchanged.
  - Otherwise: go to ITER with counter=0 and err_even=0.
- ITER, one step per cycle for all channels:
  - to_mont=1: s = {x,1'b0} at WIDTH+1 bits; x_nxt = (s >= p) ? s - p : s.
  - to_mont=0: x_nxt = x[0] ? (x + p)>>1 : x>>1. The sum is computed at WIDTH+1 bits, so there is no carry loss.
  - counter increments each step. When counter == RBITS-1 the step completes and the state goes to OUT.
  - Counter width is clog2(RBITS)+1.
- Latency: for an accept at clock edge T, out_valid is high starting from edge T+RBITS+1. For an even prime, out_valid is high from edge T+1.
- OUT:
  - out_valid=1. data_o and err_even are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE. The next job can be accepted on the following cycle; there is no same-cycle turnaround.
- Prime stability: prime and to_mont are used only from the latched copy. Input changes after accept have no effect.
- Invariant: every channel value stays < p throughout ITER, given an input < 2p and an odd p.
- Reset mid-operation: asserting reset in any state aborts the job immediately. Outputs return to reset values and no partial result is emitted.
- data_o reflects the internal registers in every state. Its value is only meaningful while out_valid=1.

Optional Feature:
Macro MDX_CH_MASK_EN.
- Defined:
  - Adds input ch_mask [NCH], sampled at accept.
  - Channels with mask bit 0 skip the ITER update. Their value after the accept reduction is passed through unchanged, and the iteration count does not change.
  - If ch_mask is all zero and p is odd, the job still runs the full RBITS cycles. This keeps latency fixed.
- Not defined: no ch_mask port; all channels are always converted.

Test Plan:
1. WIDTH=32, RBITS=32, p=0xFFFFFFFB, to_mont=1, data_i ch0=1, ch1=7, ch2=0 → after 33 cycles out_valid=1, data_o = 5, 35, 0, err_even=0.
2. Same p, to_mont=0, ch0=5, ch1=35, ch2=0xFFFFFFFA → data_o = 1, 7, 0xFFFFFFFA·2^-32 mod p (compare against a reference model). Also check a round-trip of random values < p across 1000 jobs.
3. Input above p: p=0xFFFFFFFB, ch0=0xFFFFFFFC, to_mont=1 → pre-reduced to 1, output 5.
4. Even prime: p=0x10, ch0=0x13 → out_valid one cycle after accept, err_even=1, data_o ch0=0x3.
5. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in OUT → data_o stable, in_ready=0, busy=1; release → IDLE next cycle.
   - Assert reset at ITER counter=10 → out_valid never rises, in_ready=1 after release.
6. Parameter variant WIDTH=8, RBITS=8, NCH=2, p=251, to_mont=1, data 1 and 250 → data_o 5 and 246 after 9 cycles. With MDX_CH_MASK_EN and ch_mask=2'b01 → data_o 5 and 250.

Source files
------------

// File: rtl/mont_domain_xfer_n.sv
// Converts NCH field elements at a time into or out of the Montgomery domain.
// Each job does RBITS iterations, one bit per cycle. It uses modular doubling
// for regular->Montgomery (x*2^RBITS mod p) and modular halving for
// Montgomery->regular (x*2^-RBITS mod p).
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   in_valid/in_ready job request handshake (in_ready only in IDLE)
//   to_mont           1 = into Montgomery domain, 0 = out of it (latched at accept)
//   prime             modulus p (latched at accept)
//   data_i            channel k in [k*WIDTH +: WIDTH]
//   ch_mask           per-channel enable, only present when MDX_CH_MASK_EN is defined
//   out_valid/out_ready result handshake
//   data_o            converted values, same packing as data_i
//   err_even          with out_valid: prime was even, values only pre-reduced
//   busy              state != IDLE
//
// Optional feature macro: MDX_CH_MASK_EN. When it is defined, channels whose
// mask bit is 0 keep their pre-reduced value. Latency is the same either way.

module mont_domain_xfer_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 3,
  parameter int unsigned RBITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 to_mont,
  input  logic [WIDTH-1:0]     prime,
  input  logic [NCH*WIDTH-1:0] data_i,
`ifdef MDX_CH_MASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] data_o,
  output logic                 err_even,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(RBITS) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(RBITS - 1);

  typedef enum logic [1:0] {StIdle, StIter, StOut} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]              prime_q, prime_d;
  logic                          mode_q, mode_d;
  logic                          err_q, err_d;
  logic [NCH-1:0][WIDTH-1:0]     x_q, x_d;
  logic [NCH-1:0][WIDTH-1:0]     red;
  logic [NCH-1:0][WIDTH-1:0]     step;
  logic [NCH-1:0]                act;

`ifdef MDX_CH_MASK_EN
  logic [NCH-1:0] mask_q, mask_d;
  assign act = mask_q;
`else
  assign act = '1;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH-1:0] din;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_sub;
    logic [WIDTH:0]   sum;

    assign din = data_i[k*WIDTH +: WIDTH];
    // Single conditional subtract; callers keep inputs below 2p.
    assign red[k] = (din >= prime) ? din - prime : din;

    assign dbl     = {x_q[k], 1'b0};
    assign dbl_sub = dbl - {1'b0, prime_q};
    // The extra bit keeps the carry of x + p before halving.
    assign sum     = {1'b0, x_q[k]} + {1'b0, prime_q};

    always_comb begin
      step[k] = x_q[k];
      if (mode_q) begin
        step[k] = (dbl >= {1'b0, prime_q}) ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];
      end else begin
        step[k] = x_q[k][0] ? sum[WIDTH:1] : (x_q[k] >> 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prime_d = prime_q;
    mode_d  = mode_q;
    err_d   = err_q;
    x_d     = x_q;
`ifdef MDX_CH_MASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          prime_d = prime;
          mode_d  = to_mont;
          x_d     = red;
          cnt_d   = '0;
`ifdef MDX_CH_MASK_EN
          mask_d  = ch_mask;
`endif
          // Even moduli (including 0) cannot be halved modulo p, so skip the loop.
          if (!prime[0]) begin
            err_d   = 1'b1;
            state_d = StOut;
          end else begin
            err_d   = 1'b0;
            state_d = StIter;
          end
        end
      end
      StIter: begin
        for (int k = 0; k < NCH; k++) begin
          if (act[k]) x_d[k] = step[k];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prime_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      x_q     <= '0;
`ifdef MDX_CH_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      x_q     <= x_d;
`ifdef MDX_CH_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign err_even  = err_q;
  assign data_o    = x_q;

endmodule

// File: tb/tb_mont_domain_xfer_n.sv
module tb_mont_domain_xfer_n;
  localparam int W = 32;
  localparam int N = 3;
  localparam int R = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           to_mont = 1'b0;
  logic [W-1:0]   prime = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   ch_mask = '1;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] data_o;
  logic           err_even;
  logic           busy;

  mont_domain_xfer_n #(.WIDTH(W), .NCH(N), .RBITS(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .to_mont   (to_mont),
    .prime     (prime),
    .data_i    (data_i),
`ifdef MDX_CH_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o),
    .err_even  (err_even),
    .busy      (busy)
  );

  // Small variant: WIDTH=8, NCH=2, RBITS=8.
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic        s_to_mont = 1'b1;
  logic [7:0]  s_prime = 8'd251;
  logic [15:0] s_data_i = {8'd250, 8'd1};
  logic [1:0]  s_mask = 2'b01;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [15:0] s_data_o;
  logic        s_err;
  logic        s_busy;

  mont_domain_xfer_n #(.WIDTH(8), .NCH(2), .RBITS(8)) dut_small (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .to_mont   (s_to_mont),
    .prime     (s_prime),
    .data_i    (s_data_i),
`ifdef MDX_CH_MASK_EN
    .ch_mask   (s_mask),
`endif
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .data_o    (s_data_o),
    .err_even  (s_err),
    .busy      (s_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: bound expired without the expected response", name);
  endtask

  // Reference model: modular arithmetic on the spec's definition.
  function automatic logic [31:0] powmod(input logic [31:0] b, input int e, input logic [31:0] p);
    logic [63:0] r;
    logic [63:0] bb;
    int ee;
    r  = 64'd1 % {32'd0, p};
    bb = {32'd0, b} % {32'd0, p};
    ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % {32'd0, p};
      bb = (bb * bb) % {32'd0, p};
      ee = ee >> 1;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_ch(input logic [31:0] x, input logic [31:0] p,
                                           input logic mode, input logic act);
    logic [31:0] red;
    logic [63:0] t;
    red = (x >= p) ? x - p : x;
    if (!p[0] || !act) return red;
    if (mode) t = ({32'd0, red} * {32'd0, powmod(32'd2, R, p)}) % {32'd0, p};
    else      t = ({32'd0, red} * {32'd0, powmod((p >> 1) + 32'd1, R, p)}) % {32'd0, p};
    return t[31:0];
  endfunction

  // Cycle-by-cycle compare against the model's view of the job lifecycle.
  int             phase = 0;  // 0 idle, 1 converting, 2 result held
  int             wait_cnt = 0;
  logic [N*W-1:0] exp_d = '0;
  logic           exp_err = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      phase = 0;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
    end else begin
      if (phase == 1) begin
        wait_cnt--;
        if (wait_cnt == 0) phase = 2;
      end
      check("in_ready", in_ready, phase == 0);
      check("out_valid", out_valid, phase == 2);
      check("busy", busy, phase != 0);
      if (phase == 2) begin
        for (int k = 0; k < N; k++)
          check($sformatf("data_o ch%0d", k), data_o[k*W +: W], exp_d[k*W +: W]);
        check("err_even", err_even, exp_err);
      end
      if (phase == 0 && in_valid) begin
        for (int k = 0; k < N; k++)
          exp_d[k*W +: W] = model_ch(data_i[k*W +: W], prime, to_mont, ch_mask[k]);
        exp_err  = !prime[0];
        wait_cnt = prime[0] ? R + 1 : 1;
        phase    = 1;
      end else if (phase == 2 && out_ready) begin
        phase = 0;
      end
    end
  end

  // Runs one job; called at posedge+#1 with the DUT idle. lat = edges from accept to out_valid.
  task automatic do_job(input logic [W-1:0] p, input logic mode, input logic [N*W-1:0] d,
                        input int hold, output logic [N*W-1:0] res, output logic err,
                        output int lat);
    int n;
    logic [N*W-1:0] snap;
    prime = p; to_mont = mode; data_i = d; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs to show only the latched copy matters.
    in_valid = 1'b0; prime = $urandom; to_mont = 1'($urandom);
    data_i = {$urandom, $urandom, $urandom};
    n = 0;
    while (!out_valid && n < R + 4) begin @(posedge clk); #1; n++; end
    lat = n;
    res = '0; err = 1'b0;
    if (!out_valid) begin fail("out_valid wait"); return; end
    snap = data_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold data_o", data_o, snap);
      check("hold in_ready", in_ready, 0);
      check("hold busy", busy, 1);
    end
    res = data_o; err = err_even; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle after pop", in_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] res, res2, x;
    logic           err;
    int             lat, n;
    logic [W-1:0]   p;
    logic           rose;

    repeat (3) @(posedge clk);
    #1;
    check("reset data_o", data_o, 0);
    check("reset err_even", err_even, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Model pins.
    check("model pin to", model_ch(32'd7, 32'hFFFFFFFB, 1'b1, 1'b1), 35);
    check("model pin from", model_ch(32'd35, 32'hFFFFFFFB, 1'b0, 1'b1), 7);

    // 1: into the domain.
    do_job(32'hFFFFFFFB, 1'b1, {32'd0, 32'd7, 32'd1}, 0, res, err, lat);
    check("t1 ch0", res[31:0], 5);
    check("t1 ch1", res[63:32], 35);
    check("t1 ch2", res[95:64], 0);
    check("t1 err", err, 0);
    check("t1 latency", lat, R);

    // 2: out of the domain.
    do_job(32'hFFFFFFFB, 1'b0, {32'hFFFFFFFA, 32'd35, 32'd5}, 0, res, err, lat);
    check("t2 ch0", res[31:0], 1);
    check("t2 ch1", res[63:32], 7);
    check("t2 ch2", res[95:64], model_ch(32'hFFFFFFFA, 32'hFFFFFFFB, 1'b0, 1'b1));

    // 3: input above p is pre-reduced.
    do_job(32'hFFFFFFFB, 1'b1, {32'd0, 32'd0, 32'hFFFFFFFC}, 0, res, err, lat);
    check("t3 ch0", res[31:0], 5);

    // 4: even prime.
    do_job(32'h10, 1'b1, {32'h1F, 32'h5, 32'h13}, 0, res, err, lat);
    check("t4 ch0", res[31:0], 3);
    check("t4 ch1", res[63:32], 5);
    check("t4 ch2", res[95:64], 32'hF);
    check("t4 err", err, 1);
    check("t4 latency", lat, 0);

    // 5a: backpressure.
    do_job(32'hFFFFFFFB, 1'b1, {32'd3, 32'd2, 32'd1}, 5, res, err, lat);
    check("t5 ch0", res[31:0], 5);

    // 5b: reset at counter 10 aborts the job.
    prime = 32'hFFFFFFFB; to_mont = 1'b1; data_i = {32'd3, 32'd2, 32'd1}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("t5 in_ready after reset", in_ready, 1);
    rose = 1'b0;
    for (int i = 0; i < R + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    check("t5 no out_valid after abort", rose, 0);

    // Random round trips with occasional even-prime jobs.
    for (int i = 0; i < 500; i++) begin
      p = $urandom | 32'h80000001;
      for (int k = 0; k < N; k++) x[k*W +: W] = $urandom % p;
`ifdef MDX_CH_MASK_EN
      ch_mask = 3'($urandom);
`endif
      do_job(p, 1'b1, x, $urandom_range(0, 3), res, err, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
`ifdef MDX_CH_MASK_EN
      ch_mask = 3'($urandom);
`endif
      do_job(p, 1'b0, res, $urandom_range(0, 2), res2, err, lat);
      check("round trip", res2, x);
      if (i % 25 == 0) begin
        p = ($urandom & 32'hFFFFFFFE) | 32'h80000000;
        do_job(p, 1'($urandom), {$urandom, $urandom, $urandom}, 1, res, err, lat);
        check("rand even err", err, 1);
      end
    end
    ch_mask = '1;

    // 6: small variant.
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!s_out_valid) fail("small out_valid wait");
    check("t6 latency", n, 8);
    check("t6 ch0", s_data_o[7:0], 5);
`ifdef MDX_CH_MASK_EN
    check("t6 ch1 masked", s_data_o[15:8], 250);
`else
    check("t6 ch1", s_data_o[15:8], 246);
`endif
    check("t6 err", s_err, 0);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("t6 idle", s_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
